// File: rtl/lsu_align_ctrl_if.sv
// Bus bundle for lsu_align_ctrl: the MEM-stage request/response handshake plus the
// synchronous data RAM port.
//   req_*   request from the pipeline (valid/ready)
//   resp_*  response back to the pipeline (valid/ready)
//   mem_*   RAM strobe, write enable, word address, byte strobes, write and read data
// Modports: slave is the controller side, master is the pipeline + RAM environment.
interface lsu_align_ctrl_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_store;
  logic [2:0]          req_func3;
  logic [ADDR_W-1:0]   req_addr;
  logic [XLEN-1:0]     req_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic [XLEN-1:0]     resp_rdata;
  logic                resp_misalign;
  logic                resp_illegal;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [XLEN/8-1:0]   mem_be;
  logic [XLEN-1:0]     mem_wdata;
  logic [XLEN-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_store, req_func3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misalign, resp_illegal,
    output mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_func3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misalign, resp_illegal,
    input  mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller between the MEM stage and a fixed-latency synchronous
// data RAM. One request in flight; byte-lane alignment, sign/zero extension,
// misalign/illegal detection, sub-word stores via byte strobes (USE_BE=1) or an
// internal read-modify-write (USE_BE=0).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    lsu_align_ctrl_if.slave (request, response and RAM signals)
module lsu_align_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned USE_BE = 1
) (
  input logic             clk,
  input logic             rst_n,
  lsu_align_ctrl_if.slave bus
);
  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned CNTW = 3;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StWrite, StResp} state_e;

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   word_q, word_d;   // write data (lane-positioned / merged)
  logic [NB-1:0]     be_q, be_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic              illegal_q, illegal_d;

  // Request decode, evaluated on the live inputs at the accept edge.
  logic            in_legal;
  logic            in_misalign;
  logic            in_subword;
  logic [OFFW-1:0] in_lane;
  logic [OFFW-1:0] in_amask;

  function automatic logic is_legal(input logic st, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (st) begin
      ok = !f3[2] && ((f3[1:0] != 2'd3) || (XLEN == 64));
    end else begin
      unique case (f3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: ok = 1'b1;
        3'd3, 3'd6:                   ok = (XLEN == 64);
        default:                      ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Replicate the low size bytes of d across the word; aligned accesses then land
  // their bytes on the addressed lane without a shifter.
  function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] d,
                                                input logic [1:0] f);
    logic [XLEN-1:0] r;
    int unsigned     sz;
    sz = 32'd1 << f;
    r  = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      r[i*8 +: 8] = d[(i & (sz - 1))*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [NB-1:0] lane_mask(input logic [OFFW-1:0] lane,
                                              input logic [1:0] f);
    logic [NB-1:0] m;
    int unsigned   sz;
    sz = 32'd1 << f;
    m  = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      m[i] = (i >= 32'(lane)) && (i < 32'(lane) + sz);
    end
    return m;
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] word,
                                               input logic [OFFW-1:0] lane,
                                               input logic [2:0] f3);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] r;
    logic            sgn;
    int unsigned     sz;
    sz  = 32'd1 << f3[1:0];
    sh  = word >> {lane, 3'b000};
    sgn = !f3[2] && sh[sz*8-1];
    r   = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      r[i*8 +: 8] = (i < sz) ? sh[i*8 +: 8] : {8{sgn}};
    end
    return r;
  endfunction

  always_comb begin
    in_lane     = bus.req_addr[OFFW-1:0];
    in_amask    = OFFW'((32'd1 << bus.req_func3[1:0]) - 32'd1);
    in_legal    = is_legal(bus.req_store, bus.req_func3);
    // An illegal access reports only the illegal flag.
    in_misalign = in_legal && ((in_lane & in_amask) != '0);
    in_subword  = 32'(bus.req_func3[1:0]) < OFFW;
  end

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    func3_d    = func3_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    illegal_d  = illegal_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          store_d    = bus.req_store;
          func3_d    = bus.req_func3;
          addr_d     = bus.req_addr;
          word_d     = replicate(bus.req_wdata, bus.req_func3[1:0]);
          be_d       = lane_mask(in_lane, bus.req_func3[1:0]);
          rdata_d    = '0;
          misalign_d = in_misalign;
          illegal_d  = !in_legal;
          if (!in_legal || in_misalign) begin
            state_d = StResp;
          end else if (!bus.req_store || (in_subword && (USE_BE == 0))) begin
            state_d = StIssue;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StIssue: begin
        cnt_d   = CNTW'(RD_LAT - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          if (store_q) begin
            // RMW: keep RAM bytes outside the lane mask, then write the whole word.
            for (int unsigned i = 0; i < NB; i++) begin
              word_d[i*8 +: 8] = be_q[i] ? word_q[i*8 +: 8] : bus.mem_rdata[i*8 +: 8];
            end
            be_d    = '1;
            state_d = StWrite;
          end else begin
            rdata_d = load_ext(bus.mem_rdata, addr_q[OFFW-1:0], func3_q);
            state_d = StResp;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWrite: begin
        state_d = StResp;
      end
      StResp: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      store_q    <= 1'b0;
      func3_q    <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      func3_q    <= func3_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      illegal_q  <= illegal_d;
    end
  end

  logic resp_v;
  logic write_v;

  always_comb begin
    resp_v            = (state_q == StResp);
    write_v           = (state_q == StWrite);
    // Reset gating keeps req_ready low while rst_n is held, even though state is IDLE.
    bus.req_ready     = rst_n && (state_q == StIdle);
    bus.resp_valid    = resp_v;
    bus.resp_rdata    = resp_v ? rdata_q : '0;
    bus.resp_misalign = resp_v && misalign_q;
    bus.resp_illegal  = resp_v && illegal_q;
    bus.mem_en        = (state_q == StIssue) || write_v;
    bus.mem_we        = write_v;
    bus.mem_addr      = bus.mem_en ? {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}} : '0;
    bus.mem_be        = write_v ? be_q : '0;
    bus.mem_wdata     = write_v ? word_q : '0;
  end
endmodule
